branch_predictor: RTL

//  Direct-mapped branch target buffer with 2-bit saturating direction counters.

---
 rtl/branch_predictor_pkg.sv | 26 ++
 rtl/branch_predictor_saturating_counter2.sv | 18 +
 rtl/branch_predictor.sv | 93 +++++++++
 3 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the branch target buffer.
package branch_predictor_pkg;

    localparam int unsigned BTB_ENTRIES     = 16;
    localparam int unsigned BTB_INDEX_WIDTH = $clog2(BTB_ENTRIES);
    localparam int unsigned BTB_TAG_WIDTH   = 30 - BTB_INDEX_WIDTH;

    localparam logic [1:0] BTB_COUNTER_INIT  = 2'b01;  // weakly not-taken
    localparam logic [1:0] BTB_COUNTER_ALLOC = 2'b10;  // weakly taken

    typedef struct packed {
        logic                     valid;
        logic [BTB_TAG_WIDTH-1:0] tag;
        logic [31:0]              target;
        logic [1:0]               counter;
    } btbEntry_;

    function automatic logic [BTB_INDEX_WIDTH-1:0] btb_index(input logic [31:0] pc);
        return pc[BTB_INDEX_WIDTH+1:2];
    endfunction

    function automatic logic [BTB_TAG_WIDTH-1:0] btb_tag(input logic [31:0] pc);
        return pc[31:BTB_INDEX_WIDTH+2];
    endfunction

endpackage

// File: rtl/branch_predictor_saturating_counter2.sv
// Two-bit saturating direction counter, next-state only.
module saturating_counter2 (
    input  logic [1:0] in,
    input  logic       taken,
    output logic [1:0] out
);

    // Step toward the resolved direction, holding at 00 and 11.
    always_comb begin
        out = in;
        if (taken) begin
            if (in != 2'b11) out = in + 2'b01;
        end else begin
            if (in != 2'b00) out = in - 2'b01;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters; zero-latency lookup, trained by execute.
module branch_predictor
    import branch_predictor_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] lookupAddress,
    output logic        branchPredictValid,
    output logic [31:0] branchPredictData,
    input  logic        updateValid,
    input  logic [31:0] updateAddress,
    input  logic [31:0] updateTarget,
    input  logic        updateTaken,
    input  logic        invalidateAll
);

    localparam int unsigned ENTRIES     = BTB_ENTRIES;
    localparam int unsigned INDEX_WIDTH = BTB_INDEX_WIDTH;
    localparam int unsigned TAG_WIDTH   = BTB_TAG_WIDTH;

    btbEntry_ entries_q [ENTRIES];
    btbEntry_ entries_d [ENTRIES];

    logic [INDEX_WIDTH-1:0] lk_idx;
    logic [TAG_WIDTH-1:0]   lk_tag;
    btbEntry_               lk_entry;
    logic                   lk_hit;

    logic [INDEX_WIDTH-1:0] up_idx;
    logic [TAG_WIDTH-1:0]   up_tag;
    btbEntry_               up_entry;
    logic                   up_hit;
    logic [1:0]             up_counter_next;

    assign lk_idx   = btb_index(lookupAddress);
    assign lk_tag   = btb_tag(lookupAddress);
    assign up_idx   = btb_index(updateAddress);
    assign up_tag   = btb_tag(updateAddress);
    assign lk_entry = entries_q[lk_idx];
    assign up_entry = entries_q[up_idx];
    assign up_hit   = up_entry.valid && (up_entry.tag == up_tag);

    saturating_counter2 u_counter (
        .in    (up_entry.counter),
        .taken (updateTaken),
        .out   (up_counter_next)
    );

    // Lookup reads registered state only, so a same-cycle update is not visible yet.
    always_comb begin
        lk_hit             = lk_entry.valid && (lk_entry.tag == lk_tag);
        branchPredictValid = lk_hit && lk_entry.counter[1];
        branchPredictData  = branchPredictValid ? lk_entry.target : 32'h0;
    end

    // Next table state: invalidate wins over training; a not-taken miss leaves the table alone.
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            entries_d[i] = entries_q[i];
        end
        if (invalidateAll) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries_d[i].valid   = 1'b0;
                entries_d[i].counter = BTB_COUNTER_INIT;
            end
        end else if (updateValid) begin
            if (up_hit) begin
                entries_d[up_idx].counter = up_counter_next;
                if (updateTaken) entries_d[up_idx].target = updateTarget;
            end else if (updateTaken) begin
                entries_d[up_idx].valid   = 1'b1;
                entries_d[up_idx].tag     = up_tag;
                entries_d[up_idx].target  = updateTarget;
                entries_d[up_idx].counter = BTB_COUNTER_ALLOC;
            end
        end
    end

    // Table registers with synchronous reset overriding everything else.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries_q[i] <= '{valid: 1'b0, tag: '0, target: 32'h0,
                                  counter: BTB_COUNTER_INIT};
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries_q[i] <= entries_d[i];
            end
        end
    end

endmodule
